// File: rtl/sum_run_controller.sv
// Sequencer for the byte-summing datapath. It holds a loadable operand table.
// On a start edge it pulses go and streams the operands, followed by a 0x00
// terminator. It then waits for done (with a timeout) and latches the
// match, mismatch and timeout flags.
// Optional feature macro: AUTO_RERUN_EN. While start is held, a matching run
// repeats itself after a 16-cycle gap in IDLE.
// Datapath-facing outputs are registered from the current state. go and the
// first operand therefore appear one cycle after the FSM enters GO/FEED.
module sum_run_controller #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [7:0]               wr_data,
  input  logic [$clog2(DEPTH):0]   len,
  output logic                     sum_go_l,
  output logic [7:0]               sum_inA,
  input  logic                     sum_done,
  input  logic [7:0]               sum_q,
  output logic [7:0]               ref_sum,
  output logic                     busy,
  output logic                     match,
  output logic                     mismatch,
  output logic                     timeout,
  output logic [7:0]               run_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {IDLE, GO, FEED, TERM, WAIT} state_t;

  state_t        state, next_state;
  logic [7:0]    op_table [DEPTH];
  logic [AW-1:0] idx;
  logic [LW-1:0] len_q;
  logic [LW-1:0] len_clamped;
  logic [CW-1:0] cnt;
  logic          start_q;
  logic          start_rise;
  logic          rerun_fire;
  logic [7:0]    cur_op;
  logic          last_op;

  // Combinational next values for the registered outputs and the control strobes.
  logic          go_l_c;
  logic [7:0]    ina_c;
  logic          busy_c;
  logic          run_start;
  logic          feed_add;
  logic          finish_done;
  logic          finish_to;
  logic          early_done;

  assign start_rise  = start && !start_q;
  assign cur_op      = op_table[idx];
  assign last_op     = ({1'b0, idx} == (len_q - LW'(1)));
  assign len_clamped = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;

`ifdef AUTO_RERUN_EN
  logic       rerun_armed;
  logic [3:0] gap;

  // Arm after a matching run; count IDLE cycles while start stays high.
  always_ff @(posedge clock) begin
    if (reset) begin
      rerun_armed <= 1'b0;
      gap         <= '0;
    end else if (!start || run_start || finish_to || early_done) begin
      rerun_armed <= 1'b0;
      gap         <= '0;
    end else if (finish_done) begin
      rerun_armed <= (sum_q == ref_sum);
      gap         <= '0;
    end else if (rerun_armed && state == IDLE) begin
      gap <= gap + 4'd1;
    end
  end

  assign rerun_fire = rerun_armed && start && (state == IDLE) && (gap == 4'd15);
`else
  assign rerun_fire = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic, output values and control strobes.
  always_comb begin
    next_state  = state;
    go_l_c      = 1'b1;
    ina_c       = '0;
    busy_c      = 1'b0;
    run_start   = 1'b0;
    feed_add    = 1'b0;
    finish_done = 1'b0;
    finish_to   = 1'b0;
    early_done  = 1'b0;
    case (state)
      IDLE: begin
        if (start_rise || rerun_fire) begin
          run_start  = 1'b1;
          next_state = GO;
        end
      end
      GO: begin
        busy_c = 1'b1;
        go_l_c = 1'b0;
        if (sum_done) early_done = 1'b1;
        else          next_state = (len_q != '0) ? FEED : TERM;
      end
      FEED: begin
        busy_c = 1'b1;
        ina_c  = cur_op;
        if (sum_done) begin
          early_done = 1'b1;
        end else if (cur_op == 8'h00) begin
          next_state = WAIT;
        end else begin
          feed_add = 1'b1;
          if (last_op) next_state = TERM;
        end
      end
      TERM: begin
        busy_c = 1'b1;
        if (sum_done) early_done = 1'b1;
        else          next_state = WAIT;
      end
      WAIT: begin
        busy_c = 1'b1;
        if (sum_done) begin
          finish_done = 1'b1;
          busy_c      = 1'b0;
          next_state  = IDLE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          finish_to  = 1'b1;
          busy_c     = 1'b0;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    // An early done aborts the run. Drop go and the operand right away.
    if (early_done) begin
      next_state = IDLE;
      go_l_c     = 1'b1;
      ina_c      = '0;
      busy_c     = 1'b0;
    end
  end

  // Operand table. It has no reset, and writes are accepted only in IDLE.
  always_ff @(posedge clock) begin
    if (wr_en && state == IDLE) op_table[wr_addr] <= wr_data;
  end

  // Run datapath: outputs, reference sum, index, timeout counter and flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      start_q   <= 1'b0;
      sum_go_l  <= 1'b1;
      sum_inA   <= '0;
      busy      <= 1'b0;
      ref_sum   <= '0;
      match     <= 1'b0;
      mismatch  <= 1'b0;
      timeout   <= 1'b0;
      run_count <= '0;
      idx       <= '0;
      len_q     <= '0;
      cnt       <= '0;
    end else begin
      start_q  <= start;
      sum_go_l <= go_l_c;
      sum_inA  <= ina_c;
      busy     <= busy_c;
      cnt      <= (state == WAIT) ? cnt + CW'(1) : '0;
      if (run_start) begin
        if (start_rise) len_q <= len_clamped;
        ref_sum  <= '0;
        match    <= 1'b0;
        mismatch <= 1'b0;
        timeout  <= 1'b0;
        idx      <= '0;
      end
      if (state == FEED) idx <= idx + AW'(1);
      if (feed_add) ref_sum <= ref_sum + cur_op;
      if (early_done) begin
        mismatch  <= 1'b1;
        run_count <= run_count + 8'd1;
      end
      if (finish_done) begin
        match     <= (sum_q == ref_sum);
        mismatch  <= (sum_q != ref_sum);
        run_count <= run_count + 8'd1;
      end
      if (finish_to) begin
        timeout   <= 1'b1;
        run_count <= run_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_sum_run_controller.sv
// Directed bench for sum_run_controller at DEPTH=8 and TIMEOUT=64. The bench
// plays the role of the datapath and checks outputs 1 ns after each rising edge.
module tb_sum_run_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] len;
  logic       sum_go_l;
  logic [7:0] sum_inA;
  logic       sum_done;
  logic [7:0] sum_q;
  logic [7:0] ref_sum;
  logic       busy;
  logic       match;
  logic       mismatch;
  logic       timeout;
  logic [7:0] run_count;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  sum_run_controller #(.DEPTH(8), .TIMEOUT(64)) dut (
    .clock(clock), .reset(reset), .start(start), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .len(len),
    .sum_go_l(sum_go_l), .sum_inA(sum_inA), .sum_done(sum_done), .sum_q(sum_q),
    .ref_sum(ref_sum), .busy(busy), .match(match), .mismatch(mismatch),
    .timeout(timeout), .run_count(run_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_entry(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Produce a fresh start edge. On return, the edge has been sampled and the FSM is in GO.
  task automatic begin_run(input logic [3:0] l);
    start = 1'b0;
    tick();
    len = l; start = 1'b1;
    tick();
  endtask

  task automatic expect_stream(input string tag, input logic [7:0] exp[$]);
    foreach (exp[i]) begin
      tick();
      check(tag, sum_inA, exp[i]);
    end
  endtask

  task automatic give_done(input logic [7:0] q);
    sum_done = 1'b1; sum_q = q;
    tick();
    sum_done = 1'b0;
  endtask

  initial begin
    logic       stayed_idle;
    logic [7:0] rc;
    reset = 1'b1; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    len = '0; sum_done = 1'b0; sum_q = '0;
    tick(); tick();
    check("rst_go_l", sum_go_l, 1);
    check("rst_busy", busy, 0);
    check("rst_flags", {match, mismatch, timeout}, 0);
    check("rst_run_count", run_count, 0);
    check("rst_inA", sum_inA, 0);
    reset = 1'b0;
    tick();

    // Basic run: {3,5,7,9}, len=4.
    write_entry(0, 8'd3); write_entry(1, 8'd5); write_entry(2, 8'd7); write_entry(3, 8'd9);
    begin_run(4);
    check("t1_go_pre", sum_go_l, 1);
    tick();
    check("t1_go_low", sum_go_l, 0);
    check("t1_busy", busy, 1);
    expect_stream("t1_inA", '{8'd3, 8'd5, 8'd7, 8'd9, 8'd0});
    check("t1_go_back", sum_go_l, 1);
    check("t1_ref", ref_sum, 8'h18);
    give_done(8'h18);
    check("t1_match", match, 1);
    check("t1_mismatch", mismatch, 0);
    check("t1_run_count", run_count, 1);
    check("t1_busy_end", busy, 0);

    // Reference sum wraps mod 256.
    write_entry(0, 8'hF0); write_entry(1, 8'h20);
    begin_run(2);
    tick();
    expect_stream("t2_inA", '{8'hF0, 8'h20, 8'h00});
    check("t2_ref", ref_sum, 8'h10);
    give_done(8'h10);
    check("t2_match", match, 1);

    // A zero entry terminates the stream and skips TERM. Done one cycle after the 0 lands in WAIT.
    write_entry(0, 8'd4); write_entry(1, 8'd0); write_entry(2, 8'd9);
    begin_run(3);
    tick();
    expect_stream("t3_inA", '{8'd4, 8'd0});
    check("t3_ref", ref_sum, 8'd4);
    give_done(8'd4);
    check("t3_match", match, 1);
    check("t3_mismatch", mismatch, 0);

    // Wrong result, then a rerun with the correct result.
    write_entry(0, 8'd3); write_entry(1, 8'd5); write_entry(2, 8'd7); write_entry(3, 8'd9);
    begin_run(4);
    tick();
    expect_stream("t4_inA", '{8'd3, 8'd5, 8'd7, 8'd9, 8'd0});
    give_done(8'h17);
    check("t4_mismatch", mismatch, 1);
    check("t4_match", match, 0);
    begin_run(4);
    check("t4_flags_cleared", {match, mismatch}, 0);
    tick();
    expect_stream("t4b_inA", '{8'd3, 8'd5, 8'd7, 8'd9, 8'd0});
    give_done(8'h18);
    check("t4b_match", match, 1);
    check("t4b_mismatch", mismatch, 0);
    check("t4b_run_count", run_count, 5);

    // Timeout: no done. The flag rises exactly 64 cycles after the terminator.
    begin_run(4);
    tick();
    expect_stream("t5_inA", '{8'd3, 8'd5, 8'd7, 8'd9, 8'd0});
    repeat (63) tick();
    check("t5_not_yet", timeout, 0);
    check("t5_busy_wait", busy, 1);
    tick();
    check("t5_timeout", timeout, 1);
    check("t5_busy", busy, 0);
    check("t5_run_count", run_count, 6);
    check("t5_match", match, 0);

    // Early done in FEED aborts the run.
    begin_run(4);
    tick();
    tick();
    give_done(8'h00);
    check("t6_early_mm", mismatch, 1);
    check("t6_early_go", sum_go_l, 1);
    check("t6_early_busy", busy, 0);
    check("t6_early_inA", sum_inA, 0);
    check("t6_early_rc", run_count, 7);

    // len=0 sends only the terminator. len=15 is clamped to 8 entries.
    begin_run(0);
    tick();
    check("t7_len0_go", sum_go_l, 0);
    expect_stream("t7_len0_inA", '{8'd0});
    give_done(8'd0);
    check("t7_len0_match", match, 1);
    write_entry(4, 8'd1); write_entry(5, 8'd1); write_entry(6, 8'd1); write_entry(7, 8'd1);
    begin_run(15);
    tick();
    expect_stream("t8_clamp_inA", '{8'd3, 8'd5, 8'd7, 8'd9, 8'd1, 8'd1, 8'd1, 8'd1, 8'd0});
    check("t8_clamp_ref", ref_sum, 8'h1C);
    give_done(8'h1C);
    check("t8_clamp_match", match, 1);

    // Reset in FEED. A write attempted mid-run must be dropped.
    begin_run(4);
    tick();
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hAA;
    tick();
    wr_en = 1'b0;
    check("t9_feed_inA", sum_inA, 8'd3);
    reset = 1'b1; start = 1'b0;
    tick();
    reset = 1'b0;
    check("t9_rst_go_l", sum_go_l, 1);
    check("t9_rst_busy", busy, 0);
    check("t9_rst_flags", {match, mismatch, timeout}, 0);
    check("t9_rst_rc", run_count, 0);
    check("t9_rst_ref", ref_sum, 0);

    // Table survives reset and the dropped write. Start is held across a full run.
    begin_run(1);
    tick();
    expect_stream("t10_inA", '{8'd3, 8'd0});
    give_done(8'd3);
    check("t10_match", match, 1);
    rc = run_count;
    stayed_idle = 1'b1;
    repeat (30) begin
      tick();
      if (busy !== 1'b0 || sum_go_l !== 1'b1) stayed_idle = 1'b0;
    end
    check("t10_no_retrigger", stayed_idle, 1);
    check("t10_rc_hold", run_count, rc);
    start = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sum_run_controller.md
Name: sum_run_controller

Overview:
- Sequencer for the byte-summing datapath (go_l / inA / done / Q).
- Holds a small loadable operand table and, on a start request, pulses go, streams the operands one per cycle, then presents a 0x00 terminator.
- Computes its own reference sum, waits for done with a timeout, and latches match, mismatch and timeout flags for the LED and hex-display logic.

Parameters:
- DEPTH, 8, number of operand table entries (power of 2, 2..16).
- TIMEOUT, 64, cycles to wait for sum_done after the terminator before flagging timeout.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  run request (level from a button); a run begins on its 0->1 edge only.
- wr_en  input  1  table write strobe.
- wr_addr  input  $clog2(DEPTH)  table write index.
- wr_data  input  8  table write data.
- len  input  $clog2(DEPTH)+1  number of table entries to send (0..DEPTH); sampled on the start edge.
- sum_go_l  output  1  active-low go to the datapath.
- sum_inA  output  8  operand to the datapath.
- sum_done  input  1  datapath done.
- sum_q  input  8  datapath result; valid while sum_done=1.
- ref_sum  output  8  controller's reference sum, mod 256.
- busy  output  1  high from GO through WAIT.
- match  output  1  sticky: last run had sum_q == ref_sum.
- mismatch  output  1  sticky: last run had a wrong result or an early done.
- timeout  output  1  sticky: last run saw no done within TIMEOUT.
- run_count  output  8  completed runs, wraps 255->0.

Behaviour:
- Reset values: sum_go_l=1, sum_inA=0, ref_sum=0, busy=0, match=0, mismatch=0, timeout=0, run_count=0, state=IDLE, start-edge register=0.
- Reset does not clear the operand table.
- Reset during any state returns to IDLE next cycle with the reset values above.
- States: IDLE, GO, FEED, TERM, WAIT.
- IDLE:
  - Table writes are accepted.
  - On a start rising edge: latch len, clear ref_sum/match/mismatch/timeout, idx=0, go to GO.
- GO:
  - sum_go_l=0 for exactly this one cycle; sum_inA=0; busy=1.
  - Next state is FEED if latched len>0, else TERM.
- FEED:
  - sum_inA = table[idx]; ref_sum += table[idx] (8-bit wrap).
  - idx increments each cycle; after index len-1, go to TERM.
  - If table[idx]==0: it acts as the terminator. ref_sum is unchanged and the next state is WAIT directly (TERM is skipped).
- TERM: sum_inA=0 for one cycle, then go to WAIT; the timeout counter starts at 0.
- WAIT:
  - sum_inA=0; the counter increments each cycle.
  - On sum_done=1: match=(sum_q==ref_sum), mismatch=!match, run_count+=1, go to IDLE.
  - If the counter reaches TIMEOUT-1 without done: timeout=1, run_count+=1, go to IDLE.
  - If done and the final timeout cycle coincide, done wins.
- sum_done=1 seen in GO, FEED or TERM (early done): mismatch=1, run_count+=1, go to IDLE immediately; sum_go_l returns to 1.
- Start edges while busy are ignored. The edge register still tracks start, so holding start does not retrigger a run.
- wr_en while busy: the write is dropped, and the table is unchanged.
- len > DEPTH: clamped to DEPTH.
- Latency (len=N, no zero entries): first operand appears 2 cycles after the start edge is sampled; the terminator appears N+2 cycles after it.
- The flags stay valid in IDLE until the next run starts.

Optional Feature:
- AUTO_RERUN_EN: when defined, a run that ends with match=1 automatically begins a new run (same latched len) after a 16-cycle gap in IDLE, while start stays high. Dropping start, or any mismatch or timeout, stops repetition.
- When not defined, each run requires a new start rising edge.

Test Plan:
- Load table {3,5,7,9}, len=4, start edge, datapath returns done with Q=0x18 -> go_l low 1 cycle; inA sequence 3,5,7,9,0; ref_sum=0x18; match=1; run_count=1.
- Table {0xF0,0x20}, len=2, Q=0x10 -> ref_sum=0x10 (wrap); match=1.
- Table {4,0,9}, len=3 -> inA 4 then 0 only; no TERM cycle; ref_sum=4; done with Q=4 gives match=1.
- len=4, Q=0x17 returned -> mismatch=1, match=0; a second start edge with correct Q clears mismatch and sets match.
- Datapath never asserts done, TIMEOUT=64 -> timeout=1 exactly 64 cycles after the terminator; busy=0; run_count increments.
- Assert reset in FEED, and also hold start high across a completed run -> go_l=1, busy=0, flags 0 the cycle after reset; no second run without a new start edge (AUTO_RERUN_EN undefined).
